// File: rtl/cr_prefix_attach_fetch_seq.sv
// Prefix-attach fetch sequencer: loads/reads/checks the PHD region, then optionally the PFD
// region, for one prefix request at a time, and returns a 4-bit per-request status.
module cr_prefix_attach_fetch_seq #(
  parameter int N_PHD_WORDS = 64,
  parameter int N_PFD_WORDS = 64,
  parameter int CRC_LD_WAIT = 3,
  parameter int CHK_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [5:0] req_prefix_num,
  input  logic       req_skip_pfd,
  input  logic       out_ready,
  output logic [5:0] ibp_prefix_num,
  output logic       ibp_prefix_valid,
  output logic       ibp_ld_phd_crc_addr,
  output logic       ibp_ld_pfd_crc_addr,
  output logic       ibp_inc_phd_addr,
  output logic       ibp_inc_pfd_addr,
  input  logic       pmc_phd_check_valid,
  input  logic       pmc_pfd_check_valid,
  input  logic       pmc_phd_crc_error,
  input  logic       pmc_pfd_crc_error,
  output logic       pac_phd_check_valid_ack,
  output logic       pac_pfd_check_valid_ack,
  output logic       done_valid,
  input  logic       done_ready,
  output logic [3:0] done_status,
  output logic       busy
);

  localparam logic [7:0] WAIT_LAST = (CRC_LD_WAIT > 1) ? 8'(CRC_LD_WAIT - 1) : 8'd0;
  localparam logic [7:0] TO_LAST   = (CHK_TIMEOUT > 1) ? 8'(CHK_TIMEOUT - 1) : 8'd0;

  typedef enum logic [3:0] {
    S_IDLE, S_PHD_LD, S_PHD_LW, S_PHD_RD, S_PHD_CHK,
    S_PFD_LD, S_PFD_LW, S_PFD_RD, S_PFD_CHK, S_DONE
  } state_e;

  state_e     state_q, state_d;
  logic [5:0] pnum_q, pnum_d;
  logic       skip_q, skip_d;
  logic       pvalid_q, pvalid_d;
  logic       ld_phd_q, ld_phd_d, ld_pfd_q, ld_pfd_d;
  logic       inc_phd_q, inc_phd_d, inc_pfd_q, inc_pfd_d;
  logic       ack_phd_q, ack_phd_d, ack_pfd_q, ack_pfd_d;
  logic       done_valid_q, done_valid_d;
  logic [3:0] status_q, status_d;
  logic       busy_q, busy_d;
  logic [7:0] wait_q, wait_d;
  logic [6:0] word_q, word_d;
  logic [7:0] to_q, to_d;

  // The PHD and PFD phases share one datapath; in_pfd selects the region's signals.
  logic       in_pfd, chk_valid, chk_err, acked;
  logic [6:0] n_words;

  assign in_pfd    = (state_q == S_PFD_LD) || (state_q == S_PFD_LW) ||
                     (state_q == S_PFD_RD) || (state_q == S_PFD_CHK);
  assign chk_valid = in_pfd ? pmc_pfd_check_valid : pmc_phd_check_valid;
  assign chk_err   = in_pfd ? pmc_pfd_crc_error   : pmc_phd_crc_error;
  assign acked     = in_pfd ? ack_pfd_q           : ack_phd_q;
  assign n_words   = in_pfd ? 7'(N_PFD_WORDS)     : 7'(N_PHD_WORDS);

  always_comb begin
    state_d      = state_q;
    pnum_d       = pnum_q;
    skip_d       = skip_q;
    pvalid_d     = pvalid_q;
    ld_phd_d     = 1'b0;
    ld_pfd_d     = 1'b0;
    inc_phd_d    = 1'b0;
    inc_pfd_d    = 1'b0;
    ack_phd_d    = 1'b0;
    ack_pfd_d    = 1'b0;
    done_valid_d = done_valid_q;
    status_d     = status_q;
    busy_d       = busy_q;
    wait_d       = wait_q;
    word_d       = word_q;
    to_d         = to_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          pnum_d   = req_prefix_num;
          skip_d   = req_skip_pfd;
          status_d = 4'd0;
          pvalid_d = 1'b1;
          ld_phd_d = 1'b1;
          busy_d   = 1'b1;
          state_d  = S_PHD_LD;
        end
      end
      S_PHD_LD, S_PFD_LD: begin
        wait_d  = 8'd0;
        state_d = in_pfd ? S_PFD_LW : S_PHD_LW;
      end
      S_PHD_LW, S_PFD_LW: begin
        if (wait_q >= WAIT_LAST) begin
          word_d  = 7'd0;
          state_d = in_pfd ? S_PFD_RD : S_PHD_RD;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      // Increments are registered, so RD holds one extra cycle while the last one is driven.
      S_PHD_RD, S_PFD_RD: begin
        if (word_q == n_words) begin
          to_d    = 8'd0;
          state_d = in_pfd ? S_PFD_CHK : S_PHD_CHK;
        end else if (out_ready) begin
          inc_phd_d = ~in_pfd;
          inc_pfd_d = in_pfd;
          word_d    = word_q + 7'd1;
        end
      end
      // CHK stays one cycle with the ack high; check_valid wins over a same-cycle timeout.
      S_PHD_CHK, S_PFD_CHK: begin
        if (acked) begin
          if (in_pfd || skip_q) begin
            pvalid_d     = 1'b0;
            done_valid_d = 1'b1;
            state_d      = S_DONE;
          end else begin
            ld_pfd_d = 1'b1;
            state_d  = S_PFD_LD;
          end
        end else if (chk_valid) begin
          status_d[{in_pfd, 1'b0}] = chk_err;
          ack_phd_d = ~in_pfd;
          ack_pfd_d = in_pfd;
        end else if (to_q >= TO_LAST) begin
          status_d[{in_pfd, 1'b1}] = 1'b1;
          ack_phd_d = ~in_pfd;
          ack_pfd_d = in_pfd;
        end else begin
          to_d = to_q + 8'd1;
        end
      end
      S_DONE: begin
        if (done_ready) begin
          done_valid_d = 1'b0;
          busy_d       = 1'b0;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      pnum_q       <= 6'd0;
      skip_q       <= 1'b0;
      pvalid_q     <= 1'b0;
      ld_phd_q     <= 1'b0;
      ld_pfd_q     <= 1'b0;
      inc_phd_q    <= 1'b0;
      inc_pfd_q    <= 1'b0;
      ack_phd_q    <= 1'b0;
      ack_pfd_q    <= 1'b0;
      done_valid_q <= 1'b0;
      status_q     <= 4'd0;
      busy_q       <= 1'b0;
      wait_q       <= 8'd0;
      word_q       <= 7'd0;
      to_q         <= 8'd0;
    end else begin
      state_q      <= state_d;
      pnum_q       <= pnum_d;
      skip_q       <= skip_d;
      pvalid_q     <= pvalid_d;
      ld_phd_q     <= ld_phd_d;
      ld_pfd_q     <= ld_pfd_d;
      inc_phd_q    <= inc_phd_d;
      inc_pfd_q    <= inc_pfd_d;
      ack_phd_q    <= ack_phd_d;
      ack_pfd_q    <= ack_pfd_d;
      done_valid_q <= done_valid_d;
      status_q     <= status_d;
      busy_q       <= busy_d;
      wait_q       <= wait_d;
      word_q       <= word_d;
      to_q         <= to_d;
    end
  end

  assign req_ready               = (state_q == S_IDLE);
  assign ibp_prefix_num          = pnum_q;
  assign ibp_prefix_valid        = pvalid_q;
  assign ibp_ld_phd_crc_addr     = ld_phd_q;
  assign ibp_ld_pfd_crc_addr     = ld_pfd_q;
  assign ibp_inc_phd_addr        = inc_phd_q;
  assign ibp_inc_pfd_addr        = inc_pfd_q;
  assign pac_phd_check_valid_ack = ack_phd_q;
  assign pac_pfd_check_valid_ack = ack_pfd_q;
  assign done_valid              = done_valid_q;
  assign done_status             = status_q;
  assign busy                    = busy_q;

endmodule

// File: tb/tb_cr_prefix_attach_fetch_seq.sv
// Directed + randomized bench for cr_prefix_attach_fetch_seq with a transaction-level model.
module tb_cr_prefix_attach_fetch_seq;

  localparam int N_PHD = 64;
  localparam int N_PFD = 64;
  localparam int LDW   = 3;
  localparam int TO    = 255;

  logic       clk, rst_n, req_valid, req_ready, req_skip_pfd, out_ready;
  logic [5:0] req_prefix_num, ibp_prefix_num;
  logic       ibp_prefix_valid, ibp_ld_phd_crc_addr, ibp_ld_pfd_crc_addr;
  logic       ibp_inc_phd_addr, ibp_inc_pfd_addr;
  logic       pmc_phd_check_valid, pmc_pfd_check_valid, pmc_phd_crc_error, pmc_pfd_crc_error;
  logic       pac_phd_check_valid_ack, pac_pfd_check_valid_ack;
  logic       done_valid, done_ready, busy;
  logic [3:0] done_status;

  cr_prefix_attach_fetch_seq #(
    .N_PHD_WORDS(N_PHD), .N_PFD_WORDS(N_PFD), .CRC_LD_WAIT(LDW), .CHK_TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_prefix_num(req_prefix_num), .req_skip_pfd(req_skip_pfd), .out_ready(out_ready),
    .ibp_prefix_num(ibp_prefix_num), .ibp_prefix_valid(ibp_prefix_valid),
    .ibp_ld_phd_crc_addr(ibp_ld_phd_crc_addr), .ibp_ld_pfd_crc_addr(ibp_ld_pfd_crc_addr),
    .ibp_inc_phd_addr(ibp_inc_phd_addr), .ibp_inc_pfd_addr(ibp_inc_pfd_addr),
    .pmc_phd_check_valid(pmc_phd_check_valid), .pmc_pfd_check_valid(pmc_pfd_check_valid),
    .pmc_phd_crc_error(pmc_phd_crc_error), .pmc_pfd_crc_error(pmc_pfd_crc_error),
    .pac_phd_check_valid_ack(pac_phd_check_valid_ack),
    .pac_pfd_check_valid_ack(pac_pfd_check_valid_ack),
    .done_valid(done_valid), .done_ready(done_ready), .done_status(done_status), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, failures = 0, cyc = 0;
  int n_ld_phd, n_ld_pfd, n_inc_phd, n_inc_pfd, n_ack_phd, n_ack_pfd, viol;
  int ld_phd_cyc, first_inc_phd_cyc, last_inc_phd_cyc, last_inc_pfd_cyc;
  int ack_phd_cyc, ack_pfd_cyc;
  logic [5:0] exp_pnum;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    n_ld_phd = 0; n_ld_pfd = 0; n_inc_phd = 0; n_inc_pfd = 0; n_ack_phd = 0; n_ack_pfd = 0;
    viol = 0; ld_phd_cyc = 0; first_inc_phd_cyc = 0; last_inc_phd_cyc = 0;
    last_inc_pfd_cyc = 0; ack_phd_cyc = 0; ack_pfd_cyc = 0;
  endtask

  // One clock; observe outputs just after the edge. out_ready still holds the value the
  // DUT sampled at this edge, so any increment seen now must have been allowed by it.
  task automatic step();
    @(posedge clk); #1; cyc++;
    if (ibp_ld_phd_crc_addr) begin n_ld_phd++; ld_phd_cyc = cyc; end
    if (ibp_ld_pfd_crc_addr) n_ld_pfd++;
    if (ibp_inc_phd_addr) begin
      n_inc_phd++;
      if (n_inc_phd == 1) first_inc_phd_cyc = cyc;
      if (n_inc_phd == N_PHD) last_inc_phd_cyc = cyc;
    end
    if (ibp_inc_pfd_addr) begin
      n_inc_pfd++;
      if (n_inc_pfd == N_PFD) last_inc_pfd_cyc = cyc;
    end
    if (pac_phd_check_valid_ack) begin n_ack_phd++; ack_phd_cyc = cyc; end
    if (pac_pfd_check_valid_ack) begin n_ack_pfd++; ack_pfd_cyc = cyc; end
    if (ibp_inc_phd_addr && ibp_inc_pfd_addr) viol++;
    if ((ibp_inc_phd_addr || ibp_inc_pfd_addr) && !out_ready) viol++;
    if ((ibp_inc_phd_addr || ibp_inc_pfd_addr) &&
        (ibp_ld_phd_crc_addr || ibp_ld_pfd_crc_addr ||
         pac_phd_check_valid_ack || pac_pfd_check_valid_ack)) viol++;
    if ((pac_phd_check_valid_ack || pac_pfd_check_valid_ack) && !ibp_prefix_valid) viol++;
    if (pac_phd_check_valid_ack && n_inc_phd != N_PHD) viol++;
    if (pac_pfd_check_valid_ack && n_inc_pfd != N_PFD) viol++;
    if (busy && ibp_prefix_num !== exp_pnum) viol++;
    if (done_valid && ibp_prefix_valid) viol++;
  endtask

  task automatic chk_reset_vals(input string tag);
    logic [19:0] got, exp;
    got = {req_ready, ibp_prefix_num, ibp_prefix_valid, ibp_ld_phd_crc_addr,
           ibp_ld_pfd_crc_addr, ibp_inc_phd_addr, ibp_inc_pfd_addr, pac_phd_check_valid_ack,
           pac_pfd_check_valid_ack, done_valid, done_status, busy};
    exp = {1'b1, 19'd0};
    chk(tag, 32'(got), 32'(exp));
  endtask

  // chk modes: 0 = result 4 cycles after last increment, 1 = never (timeout),
  // 2 = result presented in the cycle where the timeout is decided.
  task automatic run_txn(input logic [5:0] pn, input bit skip, input int orm,
                         input int phm, input bit phe, input int pfm, input bit pfe,
                         input int hold, input int rst_at);
    int t0;
    bit fin, ph_ck, pf_ck;
    logic [3:0] exp_st, st0;
    clr();
    exp_pnum = pn;
    chk("prefix_legal", 32'(pn != 6'd0), 1);
    chk("req_ready_idle", 32'(req_ready), 1);
    req_valid = 1'b1; req_prefix_num = pn; req_skip_pfd = skip;
    step();
    req_valid = 1'b0; req_prefix_num = 6'($urandom); req_skip_pfd = 1'($urandom);
    chk("accept_busy", 32'(busy), 1);
    chk("accept_ld_phd", 32'(ibp_ld_phd_crc_addr), 1);
    t0 = cyc; fin = 1'b0;
    while (!fin && (cyc - t0) < 3000) begin
      case (orm)
        0:       out_ready = 1'b1;
        1:       out_ready = ~out_ready;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
      ph_ck = (n_inc_phd == N_PHD) && (n_ack_phd == 0);
      pf_ck = (n_inc_pfd == N_PFD) && (n_ack_pfd == 0);
      if (ph_ck)
        pmc_phd_check_valid = (phm == 0) ? (cyc == last_inc_phd_cyc + 4) :
                              (phm == 2) ? (cyc == last_inc_phd_cyc + TO) : 1'b0;
      else
        pmc_phd_check_valid = ($urandom_range(0, 7) == 0);
      if (pf_ck)
        pmc_pfd_check_valid = (pfm == 0) ? (cyc == last_inc_pfd_cyc + 4) :
                              (pfm == 2) ? (cyc == last_inc_pfd_cyc + TO) : 1'b0;
      else
        pmc_pfd_check_valid = ($urandom_range(0, 7) == 0);
      pmc_phd_crc_error = (ph_ck && pmc_phd_check_valid) ? phe : 1'($urandom);
      pmc_pfd_crc_error = (pf_ck && pmc_pfd_check_valid) ? pfe : 1'($urandom);
      step();
      if (rst_at > 0 && n_inc_pfd == rst_at) begin
        rst_n = 1'b0; #2;
        chk_reset_vals("midop_reset_vals");
        return;
      end
      fin = done_valid;
    end
    pmc_phd_check_valid = 1'b0; pmc_pfd_check_valid = 1'b0;
    if (!fin) begin
      chk("done_reached", 0, 1);
      return;
    end
    exp_st[0] = (phm == 1) ? 1'b0 : phe;
    exp_st[1] = (phm == 1);
    exp_st[2] = skip ? 1'b0 : ((pfm == 1) ? 1'b0 : pfe);
    exp_st[3] = skip ? 1'b0 : (pfm == 1);
    chk("done_status", 32'(done_status), 32'(exp_st));
    chk("ld_phd_cnt", n_ld_phd, 1);
    chk("inc_phd_cnt", n_inc_phd, N_PHD);
    chk("ack_phd_cnt", n_ack_phd, 1);
    chk("phd_ld_wait", 32'((first_inc_phd_cyc - ld_phd_cyc) >= LDW + 1), 1);
    chk("phd_ack_delay", ack_phd_cyc - last_inc_phd_cyc, (phm == 0) ? 5 : TO + 1);
    chk("ld_pfd_cnt", n_ld_pfd, skip ? 0 : 1);
    chk("inc_pfd_cnt", n_inc_pfd, skip ? 0 : N_PFD);
    chk("ack_pfd_cnt", n_ack_pfd, skip ? 0 : 1);
    if (!skip) chk("pfd_ack_delay", ack_pfd_cyc - last_inc_pfd_cyc, (pfm == 0) ? 5 : TO + 1);
    if (orm == 1) chk("bp_phd_span", last_inc_phd_cyc - first_inc_phd_cyc, 2 * N_PHD - 2);
    chk("invariants", viol, 0);
    st0 = done_status;
    done_ready = 1'b0;
    for (int i = 0; i < hold; i++) step();
    chk("done_held", 32'({done_valid, done_status}), 32'({1'b1, st0}));
    done_ready = 1'b1;
    step();
    done_ready = 1'b0;
    chk("post_done_busy", 32'({busy, done_valid, req_ready}), 32'(3'b001));
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_prefix_num = 6'd0; req_skip_pfd = 1'b0;
    out_ready = 1'b0; pmc_phd_check_valid = 1'b0; pmc_pfd_check_valid = 1'b0;
    pmc_phd_crc_error = 1'b0; pmc_pfd_crc_error = 1'b0; done_ready = 1'b0;
    exp_pnum = 6'd0;
    clr();
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset_vals");
    rst_n = 1'b1;
    step();

    // stray check results while idle must not be acknowledged
    pmc_phd_check_valid = 1'b1; pmc_pfd_check_valid = 1'b1;
    repeat (3) step();
    pmc_phd_check_valid = 1'b0; pmc_pfd_check_valid = 1'b0;
    step();
    chk("idle_stray_ack", n_ack_phd + n_ack_pfd, 0);
    chk("idle_stray_busy", 32'(busy), 0);

    run_txn(6'd5,  1'b0, 0, 0, 1'b0, 0, 1'b0, 0, 0);  // basic
    run_txn(6'd5,  1'b0, 1, 0, 1'b0, 0, 1'b0, 2, 0);  // backpressure toggle
    run_txn(6'd9,  1'b0, 0, 0, 1'b0, 0, 1'b1, 3, 0);  // PFD CRC error
    run_txn(6'd17, 1'b0, 0, 1, 1'b0, 0, 1'b0, 0, 0);  // PHD timeout
    run_txn(6'd33, 1'b0, 0, 2, 1'b1, 0, 1'b0, 0, 0);  // check_valid on timeout cycle
    run_txn(6'd63, 1'b1, 2, 0, 1'b1, 0, 1'b0, 1, 0);  // skip PFD
    for (int k = 0; k < 3; k++)
      run_txn(6'($urandom_range(1, 63)), 1'($urandom), 2, 0, 1'($urandom),
              $urandom_range(0, 2) == 1 ? 1 : 0, 1'($urandom), $urandom_range(0, 3), 0);

    run_txn(6'd7, 1'b0, 2, 0, 1'b0, 0, 1'b0, 0, 10);  // reset mid PFD_RD
    #2;
    rst_n = 1'b1;
    step();
    chk_reset_vals("after_reset_idle");
    run_txn(6'd12, 1'b0, 0, 0, 1'b1, 0, 1'b1, 0, 0);  // recovery

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cr_prefix_attach_fetch_seq.md
Name: cr_prefix_attach_fetch_seq

Overview:
Sequencer for the prefix-attach memory/CRC-check datapath. It accepts one prefix-fetch request at a time and drives the prefix-number, CRC-address-load and address-increment controls. It then waits for each CRC check result, acknowledges it, and returns a per-request status. The PHD region is always fetched first, then the PFD region. It sits between the prefix-attach input pipe and the memory/CRC controller and replaces the ad-hoc control pulses currently generated upstream.

Parameters:
N_PHD_WORDS, 64, number of PHD address increments issued per request (1..127)
N_PFD_WORDS, 64, number of PFD address increments issued per request (1..127)
CRC_LD_WAIT, 3, cycles held after a CRC-address-load pulse before the first increment (covers load -> crc_valid -> capture)
CHK_TIMEOUT, 255, max cycles to wait for a check result before flagging a timeout (8-bit counter)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  request accepted when valid&ready
req_prefix_num  in  6  prefix index, 1..63
req_skip_pfd  in  1  fetch and check PHD only
out_ready  in  1  downstream can take a word; gates increments
ibp_prefix_num  out  6  registered prefix index
ibp_prefix_valid  out  1  memory enable, high from PHD_LD through the last check state
ibp_ld_phd_crc_addr  out  1  one-cycle PHD CRC load pulse
ibp_ld_pfd_crc_addr  out  1  one-cycle PFD CRC load pulse
ibp_inc_phd_addr  out  1  PHD word increment
ibp_inc_pfd_addr  out  1  PFD word increment
pmc_phd_check_valid  in  1  PHD CRC result ready
pmc_pfd_check_valid  in  1  PFD CRC result ready
pmc_phd_crc_error  in  1  PHD CRC mismatch, qualified by check_valid
pmc_pfd_crc_error  in  1  PFD CRC mismatch, qualified by check_valid
pac_phd_check_valid_ack  out  1  one-cycle ack of the PHD result
pac_pfd_check_valid_ack  out  1  one-cycle ack of the PFD result
done_valid  out  1  status valid, held until done_ready
done_ready  in  1  status consumed
done_status  out  4  {pfd_timeout, pfd_err, phd_timeout, phd_err}
busy  out  1  state != IDLE

Behaviour:
- Clock and reset: single clock clk; reset rst_n asynchronous active-low.
- Reset values: state=IDLE, all outputs 0 except req_ready=1, ibp_prefix_num=0, done_status=0.
- Registered outputs: every output is registered except req_ready, which is (state==IDLE).
- IDLE: on req_valid&req_ready:
  - latch prefix_num and skip_pfd; clear the status bits;
  - go to PHD_LD.
- req_prefix_num==0 is illegal. The block does not check it; it is an assertion in the bench.
- PHD_LD: ibp_ld_phd_crc_addr=1 for exactly 1 cycle; ibp_prefix_valid rises the same cycle. Go to PHD_LW.
- PHD_LW: wait counter runs CRC_LD_WAIT cycles, then go to PHD_RD.
- PHD_RD:
  - ibp_inc_phd_addr = out_ready, one increment per cycle when asserted;
  - 7-bit word counter counts increments;
  - after N_PHD_WORDS increments go to PHD_CHK;
  - out_ready low stalls with no increment and no state change.
- PHD_CHK:
  - 8-bit timeout counter starts at 0;
  - when pmc_phd_check_valid=1: latch phd_err=pmc_phd_crc_error, pulse pac_phd_check_valid_ack for 1 cycle, go to PFD_LD (or DONE if skip_pfd);
  - if the counter reaches CHK_TIMEOUT first: set phd_timeout, pulse the ack anyway (this also clears the controller CRC accumulator), go to the next state.
  - If check_valid and timeout occur in the same cycle, check_valid wins: timeout stays clear and the error is latched.
- PFD_LD / PFD_LW / PFD_RD / PFD_CHK: identical to the PHD states, using the pfd signals and N_PFD_WORDS.
- DONE:
  - ibp_prefix_valid=0;
  - done_valid=1 with done_status held stable until done_ready;
  - on done_valid&done_ready go to IDLE;
  - a new request can be accepted on the cycle after the return to IDLE (1 bubble).
- Ack rule: the ack is never asserted outside a CHK state; at most one ack per region per request.
- Stray check: pmc_*_check_valid arriving outside the matching CHK state is ignored, with no ack.
- Increment mutual exclusion: inc_phd and inc_pfd are never high together, and never high in LD/LW/CHK states.
- Reset mid-operation: returns immediately to IDLE with all pulses low. No partial status is reported.
- Counter wrap: counters are cleared on entry to each state, so no wrap is possible within legal parameter ranges.

Test Plan:
- Basic: prefix 5, out_ready=1, check_valid 4 cycles after the last increment with error=0 -> inc_phd pulses 64 consecutive cycles, ld_phd 1 pulse, one ack each for PHD and PFD, done_status=4'b0000, busy low 1 cycle after done_ready.
- Backpressure: out_ready toggling 1/0 in PHD_RD -> exactly 64 inc_phd pulses over 128 cycles; ibp_prefix_num stays 5 throughout.
- CRC error: pmc_pfd_crc_error=1 at pfd check_valid -> done_status=4'b0100; pac_pfd ack single cycle.
- Timeout: no phd check_valid -> ack at cycle 255 of PHD_CHK, done_status bit0..1=2'b10, PFD phase still executes.
- Same-cycle: check_valid on the timeout cycle -> no timeout bit, error latched; stray pmc_phd_check_valid in IDLE -> no ack.
- skip_pfd=1, prefix 63 -> no ld_pfd or inc_pfd pulses; done after PHD; reset asserted mid-PFD_RD -> all outputs at reset values, req_ready=1.
